phase_offset_gen: RTL

- Stimulus source for the phase-detection path. It generates a reference square wave and a second "generated" square wave of the same period, with a programmable signed edge offset counted in fpga_clk_i cycles.
- It is the driving end of the PhaseDetector interface. It feeds reference_i/generated_i so the detector and the ADPLL error paths can be exercised with known, exact phase errors, on the bench or on the board.
- Settings are double-buffered and take effect only at a period boundary, so output edges never glitch.

---
 rtl/phase_offset_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/phase_offset_gen.sv
// phase_offset_gen: drives a reference square wave and a phase-shifted copy
// of the same period. The offset is counted in fpga_clk_i cycles. New
// settings wait in shadow registers and are applied at a period wrap, so the
// outputs never glitch.
module phase_offset_gen #(
  parameter int                      WIDTH        = 8,
  parameter int                      PERIOD_WIDTH = 12,
  parameter logic [PERIOD_WIDTH-1:0] RESET_HALF   = 12'd8
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [PERIOD_WIDTH-1:0] half_period_i,
  input  logic [WIDTH-1:0]        offset_i,
  output logic                    reference_o,
  output logic                    generated_o,
  output logic                    pending_o,
  output logic [WIDTH-1:0]        active_offset_o
);

  // The count must reach 2H-1, so it needs one bit more than H.
  // The signed working width leaves headroom for count - offset.
  localparam int CW = PERIOD_WIDTH + 1;
  localparam int SW = PERIOD_WIDTH + 2;

  logic [CW-1:0]           count;
  logic [PERIOD_WIDTH-1:0] act_half;
  logic [PERIOD_WIDTH-1:0] sh_half;
  logic [WIDTH-1:0]        act_off;
  logic [WIDTH-1:0]        sh_off;

  logic [CW-1:0]           period_last;
  logic                    wrap;
  logic [SW-1:0]           two_h;
  logic [SW-1:0]           off_ext;
  logic [SW-1:0]           diff;
  logic [SW-1:0]           gcount;
  logic                    ref_next;
  logic                    gen_next;

  logic [PERIOD_WIDTH-1:0] h_eff;
  logic [SW-1:0]           lim;
  logic [SW-1:0]           in_off_ext;
  logic [SW-1:0]           in_off_neg;
  logic [SW-1:0]           sat_off_ext;
  logic [WIDTH-1:0]        sat_off;

  assign period_last = {act_half, 1'b0} - CW'(1);
  assign wrap        = (count == period_last);

  // Phase of the generated wave: (count - offset) mod 2H using one
  // conditional correction. |offset| < H keeps the difference within one
  // period of range.
  always_comb begin
    two_h   = {1'b0, act_half, 1'b0};
    off_ext = {{(SW-WIDTH){act_off[WIDTH-1]}}, act_off};
    diff    = {1'b0, count} - off_ext;
    gcount  = diff;
    if (diff[SW-1]) begin
      gcount = diff + two_h;
    end else if (diff >= two_h) begin
      gcount = diff - two_h;
    end
    ref_next = ({1'b0, count} < {1'b0, act_half});
    gen_next = (gcount < {2'b0, act_half});
  end

  // Clamp the incoming request when it is loaded: H >= 2, |offset| <= H-1.
  always_comb begin
    h_eff       = (half_period_i < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : half_period_i;
    lim         = {2'b0, h_eff} - SW'(1);
    in_off_ext  = {{(SW-WIDTH){offset_i[WIDTH-1]}}, offset_i};
    in_off_neg  = ~in_off_ext + SW'(1);
    sat_off_ext = in_off_ext;
    if (!in_off_ext[SW-1] && (in_off_ext > lim)) begin
      sat_off_ext = lim;
    end else if (in_off_ext[SW-1] && (in_off_neg > lim)) begin
      sat_off_ext = ~lim + SW'(1);
    end
    sat_off = sat_off_ext[WIDTH-1:0];
  end

  // Period counter, registered outputs, and the shadow/apply handshake.
  // Apply uses the shadow as it stood before this edge, so a load landing on
  // the wrap edge waits for the next wrap.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      count       <= '0;
      act_half    <= RESET_HALF;
      act_off     <= '0;
      sh_half     <= RESET_HALF;
      sh_off      <= '0;
      pending_o   <= 1'b0;
      reference_o <= 1'b0;
      generated_o <= 1'b0;
    end else begin
      if (enable_i) begin
        reference_o <= ref_next;
        generated_o <= gen_next;
        if (wrap) begin
          count <= '0;
          if (pending_o) begin
            act_half  <= sh_half;
            act_off   <= sh_off;
            pending_o <= 1'b0;
          end
        end else begin
          count <= count + CW'(1);
        end
      end
      if (load_i) begin
        sh_half   <= h_eff;
        sh_off    <= sat_off;
        pending_o <= 1'b1;
      end
    end
  end

  assign active_offset_o = act_off;

endmodule
